multicycle_control_fsm: RTL and testbench

//  Main sequencer for the riscy32 multicycle core: walks each RV32I instruction through FETCH/DECODE/EXECUTE/MEM/WB,

---
 rtl/riscy32_pkg.sv | 60 ++++++
 rtl/branch_unit.sv | 26 ++
 rtl/multicycle_control_fsm.sv | 162 ++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscy32_pkg.sv
// Shared encodings for the riscy32 multicycle core: FSM states, datapath
// select codes, ALU op constants and RV32I opcodes.
package riscy32_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_EXECU    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_BR  = 4'h8;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/branch_unit.sv
// Branch condition resolution from registered ALU flags {N,Z,C,V}.
module branch_unit (
  input  logic [2:0] funct3,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, c, v;

  always_comb begin
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (funct3)
      3'b000:  taken = z;
      3'b001:  taken = ~z;
      3'b100:  taken = n ^ v;
      3'b101:  taken = ~(n ^ v);
      3'b110:  taken = ~c;
      3'b111:  taken = c;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WB control for the
// shared-ALU, unified-memory datapath with a memory ready handshake.
module multicycle_control_fsm
  import riscy32_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic [3:0] flags,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       InstrDone,
  output logic       IllegalInstr
);

  state_t state, next_state;
  logic   taken;

  branch_unit u_branch (
    .funct3 (funct3),
    .flags  (flags),
    .taken  (taken)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Moore decode, except the MemReady-gated strobes and branch PCWrite,
  // which must react within the cycle to avoid an extra state per wait.
  always_comb begin
    next_state   = S_FETCH;
    MemReq       = 1'b0;
    MemWrite     = 1'b0;
    AdrSrc       = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    ResultSrc    = RES_ALUOUT;
    ALUControl   = ALU_ADD;
    InstrDone    = 1'b0;
    IllegalInstr = 1'b0;
    ImmSrc       = imm_src_of(op);

    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = S_DECODE;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_LUI:            next_state = S_EXECU;
          OP_BRANCH:         next_state = S_BEQ;
          OP_JAL:            next_state = S_JAL;
          default:           IllegalInstr = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemReq     = 1'b1;
        AdrSrc     = 1'b1;
        next_state = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (MemReady) InstrDone = 1'b1;
        else          next_state = S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = {funct7, funct3};
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = {(funct3 == 3'b101) ? funct7 : 1'b0, funct3};
        next_state = S_ALUWB;
      end
      S_EXECU: begin
        ALUSrcA    = SRCA_ZERO;
        ALUSrcB    = SRCB_IMM;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = ALU_BR;
        PCWrite    = taken;
        InstrDone  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        PCWrite    = 1'b1;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase

    if (reset) begin
      MemReq       = 1'b0;
      MemWrite     = 1'b0;
      AdrSrc       = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = '0;
      ALUSrcB      = '0;
      ResultSrc    = '0;
      ImmSrc       = '0;
      ALUControl   = '0;
      InstrDone    = 1'b0;
      IllegalInstr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: each issued instruction pushes an expected per-instruction
// summary; a monitor accumulates DUT activity and compares at InstrDone/IllegalInstr.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic [3:0] flags;
  logic       MemReady;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       InstrDone, IllegalInstr;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .flags(flags), .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .InstrDone(InstrDone), .IllegalInstr(IllegalInstr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       base;
    int       rw;
    int       pc;
    int       mw;
    int       mr;
    bit       has_alu;
    bit [3:0] alu;
    bit [1:0] rsrc;
    bit [2:0] imm;
    bit       illegal;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   end_seen;
  int unsigned low_left = 0;
  int unsigned ready_pct = 100;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: what one instruction should do, from the ISA-level rules.
  function automatic exp_t model(input bit [6:0] o, input bit [2:0] f3,
                                 input bit f7, input bit [3:0] fl);
    exp_t e;
    bit n, z, c, v, tk;
    n = fl[3]; z = fl[2]; c = fl[1]; v = fl[0];
    e = '{base: 2, rw: 0, pc: 1, mw: 0, mr: 0, has_alu: 0, alu: 4'h0,
          rsrc: 2'b00, imm: 3'b000, illegal: 1};
    case (o)
      7'b0000011: e = '{5, 1, 1, 0, 1, 1, 4'h0, 2'b01, 3'b000, 0};
      7'b0100011: e = '{4, 0, 1, 1, 0, 1, 4'h0, 2'b00, 3'b001, 0};
      7'b0110011: e = '{4, 1, 1, 0, 0, 1, {f7, f3}, 2'b00, 3'b000, 0};
      7'b0010011: e = '{4, 1, 1, 0, 0, 1, {(f3 == 3'd5) ? f7 : 1'b0, f3}, 2'b00, 3'b000, 0};
      7'b0110111: e = '{4, 1, 1, 0, 0, 0, 4'h0, 2'b00, 3'b100, 0};
      7'b1101111: e = '{4, 1, 2, 0, 0, 0, 4'h0, 2'b00, 3'b011, 0};
      7'b1100011: begin
        case (f3)
          3'd0: tk = z;
          3'd1: tk = !z;
          3'd4: tk = (n != v);
          3'd5: tk = (n == v);
          3'd6: tk = !c;
          3'd7: tk = c;
          default: tk = 0;
        endcase
        e = '{3, 0, 1 + int'(tk), 0, 0, 1, 4'h8, 2'b00, 3'b010, 0};
      end
      default: ;
    endcase
    return e;
  endfunction

  int cyc, stall, rw, pcw, irw, mw, mr, bad;
  bit alu_seen;
  logic [3:0] alu_cap;
  logic [1:0] rs_cap;

  task automatic clear_acc();
    cyc = 0; stall = 0; rw = 0; pcw = 0; irw = 0; mw = 0; mr = 0; bad = 0;
    alu_seen = 0; alu_cap = '0; rs_cap = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      clear_acc();
      chk("reset_outputs_zero",
          int'({MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA,
                ALUSrcB, ResultSrc, ImmSrc, ALUControl, InstrDone, IllegalInstr}), 0);
    end else begin
      cyc++;
      if (MemReq && !MemReady) stall++;
      if (RegWrite) begin rw++; rs_cap = ResultSrc; end
      if (PCWrite) pcw++;
      if (IRWrite) irw++;
      if (MemReq && MemReady && MemWrite) mw++;
      if (MemReq && MemReady && AdrSrc && !MemWrite) mr++;
      if (MemWrite && !MemReq) bad++;
      if (ALUSrcA == 2'b10 && !alu_seen) begin alu_seen = 1; alu_cap = ALUControl; end
      if (InstrDone || IllegalInstr) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_end: got end pulse expected none at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("active_cycles", cyc - stall, e.base);
          chk("regwrite_cnt", rw, e.rw);
          chk("pcwrite_cnt", pcw, e.pc);
          chk("irwrite_cnt", irw, 1);
          chk("memwrite_cnt", mw, e.mw);
          chk("memread_cnt", mr, e.mr);
          chk("memwrite_without_req", bad, 0);
          chk("illegal", int'(IllegalInstr), int'(e.illegal));
          chk("done_pulse", int'(InstrDone), int'(!e.illegal));
          chk("imm_src", int'(ImmSrc), int'(e.imm));
          chk("alu_rs1_used", int'(alu_seen), int'(e.has_alu));
          if (e.has_alu && alu_seen) chk("alu_ctrl", int'(alu_cap), int'(e.alu));
          if (e.rw > 0) chk("result_src_wb", int'(rs_cap), int'(e.rsrc));
        end
        end_seen = 1;
        clear_acc();
      end
    end
  end

  task automatic drive_ready();
    if (low_left > 0 && MemReq && AdrSrc && !MemWrite) begin
      MemReady = 1'b0;
      low_left--;
    end else begin
      MemReady = ($urandom_range(1, 100) <= ready_pct);
    end
  endtask

  // Called with the DUT in FETCH, just after a rising edge.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [3:0] fl);
    bit done;
    q.push_back(model(o, f3, f7, fl));
    op = o; funct3 = f3; funct7 = f7; flags = fl;
    end_seen = 0;
    done = 0;
    drive_ready();
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (end_seen) done = 1;
      else drive_ready();
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL instr_timeout: op=%b got no end pulse expected one", o);
      q.delete();
    end
  endtask

  logic [6:0] ops [8];

  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b0110111, 7'b1100011, 7'b1101111, 7'b1111111};
    clear_acc();
    reset = 1; op = 7'b0110011; funct3 = '0; funct7 = 0; flags = '0; MemReady = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("fetch_memreq_after_reset", int'(MemReq), 1);
    chk("fetch_adrsrc_after_reset", int'(AdrSrc), 0);
    @(posedge clk); #1;

    ready_pct = 100;
    run_instr(7'b0110011, 3'd0, 1'b0, 4'h0);
    run_instr(7'b0110011, 3'd0, 1'b1, 4'h0);
    run_instr(7'b0010011, 3'd0, 1'b1, 4'h0);
    run_instr(7'b0010011, 3'd5, 1'b1, 4'h0);
    low_left = 3;
    run_instr(7'b0000011, 3'd2, 1'b0, 4'h0);
    chk("load_wait_consumed", int'(low_left), 0);
    run_instr(7'b1100011, 3'd0, 1'b0, 4'b0100);
    run_instr(7'b1100011, 3'd1, 1'b0, 4'b0100);
    run_instr(7'b1100011, 3'd4, 1'b0, 4'b1000);
    run_instr(7'b1100011, 3'd5, 1'b0, 4'b1000);
    run_instr(7'b1100011, 3'd6, 1'b0, 4'b0000);
    run_instr(7'b1100011, 3'd7, 1'b0, 4'b0000);
    run_instr(7'b1100011, 3'd2, 1'b0, 4'b0100);
    run_instr(7'b0100011, 3'd2, 1'b0, 4'h0);
    run_instr(7'b1101111, 3'd0, 1'b0, 4'h0);
    run_instr(7'b0110111, 3'd0, 1'b0, 4'h0);
    run_instr(7'b1111111, 3'd0, 1'b0, 4'h0);
    run_instr(7'b0110011, 3'd7, 1'b0, 4'h0);

    // Abandon a load while it waits in MEMREAD.
    op = 7'b0000011; funct3 = 3'd2; MemReady = 1;
    begin
      bit hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
        @(posedge clk); #1;
        if (MemReq && AdrSrc) hit = 1;
      end
      chk("reached_memread", int'(hit), 1);
    end
    MemReady = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("after_reset_memreq", int'(MemReq), 1);
    chk("after_reset_adrsrc", int'(AdrSrc), 0);
    chk("after_reset_regwrite", int'(RegWrite), 0);
    @(posedge clk); #1;

    ready_pct = 70;
    for (int n = 0; n < 200; n++) begin
      run_instr(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    chk("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
